// File: rtl/stream_pkt_arbiter.sv
// Packet-level round-robin arbiter: NUM_PORTS byte-strobed streams share one registered output stage.
// A grant is locked from the first beat of a packet to the beat carrying last.
module stream_pkt_arbiter #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    localparam int unsigned ID_WIDTH   = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            cen,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] din,
    input  logic [NUM_PORTS*STRB_WIDTH-1:0] din_strb,
    input  logic [NUM_PORTS-1:0]            din_last,
    input  logic [NUM_PORTS-1:0]            din_valid,
    output logic [NUM_PORTS-1:0]            din_ready,
    output logic [DATA_WIDTH-1:0]           dout,
    output logic [STRB_WIDTH-1:0]           dout_strb,
    output logic                            dout_last,
    output logic [ID_WIDTH-1:0]             dout_id,
    output logic                            dout_valid,
    input  logic                            dout_ready
);

    if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_num_ports
        $error("stream_pkt_arbiter: NUM_PORTS must be in 2..16");
    end
    if (DATA_WIDTH == 0 || (DATA_WIDTH % 8) != 0) begin : g_bad_data_width
        $error("stream_pkt_arbiter: DATA_WIDTH must be a non-zero multiple of 8");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ID_WIDTH-1:0]   r_grant;
    logic [ID_WIDTH-1:0]   w_grant_nxt;
    logic [ID_WIDTH-1:0]   r_last_grant;
    logic [ID_WIDTH-1:0]   w_last_grant_nxt;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [DATA_WIDTH-1:0] w_dout_nxt;
    logic [STRB_WIDTH-1:0] r_dout_strb;
    logic [STRB_WIDTH-1:0] w_dout_strb_nxt;
    logic                  r_dout_last;
    logic                  w_dout_last_nxt;
    logic [ID_WIDTH-1:0]   r_dout_id;
    logic [ID_WIDTH-1:0]   w_dout_id_nxt;
    logic                  r_dout_valid;
    logic                  w_dout_valid_nxt;

    logic [DATA_WIDTH-1:0] w_port_data [NUM_PORTS];
    logic [STRB_WIDTH-1:0] w_port_strb [NUM_PORTS];
    logic [ID_WIDTH-1:0]   w_pick;
    logic                  w_any_req;
    int unsigned           w_idx;
    logic                  w_out_free;
    logic                  w_accept;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign w_port_data[g] = din[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_port_strb[g] = din_strb[g*STRB_WIDTH +: STRB_WIDTH];
    end

    // First requester after the previous winner, wrapping modulo NUM_PORTS.
    always_comb begin : p_pick
        w_pick    = '0;
        w_any_req = 1'b0;
        w_idx     = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            w_idx = (32'(r_last_grant) + k) % NUM_PORTS;
            if (!w_any_req && din_valid[ID_WIDTH'(w_idx)]) begin
                w_pick    = ID_WIDTH'(w_idx);
                w_any_req = 1'b1;
            end
        end
    end

    assign w_out_free = ~r_dout_valid | dout_ready;
    assign w_accept   = cen & (r_state == S_BUSY) & w_out_free & din_valid[r_grant];

    always_comb begin : p_ready
        din_ready = '0;
        if (cen && (r_state == S_BUSY) && w_out_free) begin
            din_ready[r_grant] = 1'b1;
        end
    end

    always_comb begin : p_next
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_dout_nxt       = r_dout;
        w_dout_strb_nxt  = r_dout_strb;
        w_dout_last_nxt  = r_dout_last;
        w_dout_id_nxt    = r_dout_id;
        w_dout_valid_nxt = r_dout_valid;
        if (cen) begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        w_grant_nxt      = w_pick;
                        w_last_grant_nxt = w_pick;
                        w_state_nxt      = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_accept && din_last[r_grant]) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
            // Accept and drain in the same cycle is a pass-through load.
            if (w_accept) begin
                w_dout_nxt       = w_port_data[r_grant];
                w_dout_strb_nxt  = w_port_strb[r_grant];
                w_dout_last_nxt  = din_last[r_grant];
                w_dout_id_nxt    = r_grant;
                w_dout_valid_nxt = 1'b1;
            end else if (dout_ready) begin
                w_dout_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin : p_regs
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= ID_WIDTH'(NUM_PORTS - 1);
            r_dout       <= '0;
            r_dout_strb  <= '0;
            r_dout_last  <= 1'b0;
            r_dout_id    <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_strb  <= w_dout_strb_nxt;
            r_dout_last  <= w_dout_last_nxt;
            r_dout_id    <= w_dout_id_nxt;
            r_dout_valid <= w_dout_valid_nxt;
        end
    end

    assign dout       = r_dout;
    assign dout_strb  = r_dout_strb;
    assign dout_last  = r_dout_last;
    assign dout_id    = r_dout_id;
    assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// Bench for stream_pkt_arbiter: directed scenarios plus randomized traffic, scored against a
// packet-level round-robin model that predicts the whole output beat stream from the queued packets.
module tb_stream_pkt_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned IW = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
        logic [IW-1:0] id;
    } beat_t;

    logic             clk = 1'b0;
    logic             rstn;
    logic             cen;
    logic [NP*DW-1:0] din;
    logic [NP*SW-1:0] din_strb;
    logic [NP-1:0]    din_last;
    logic [NP-1:0]    din_valid;
    logic [NP-1:0]    din_ready;
    logic [DW-1:0]    dout;
    logic [SW-1:0]    dout_strb;
    logic             dout_last;
    logic [IW-1:0]    dout_id;
    logic             dout_valid;
    logic             dout_ready;

    stream_pkt_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cen        (cen),
        .din        (din),
        .din_strb   (din_strb),
        .din_last   (din_last),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_strb  (dout_strb),
        .dout_last  (dout_last),
        .dout_id    (dout_id),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    beat_t       src_q  [NP][$];
    beat_t       pend_q [NP][$];
    beat_t       exp_q  [$];
    int          acc_cnt [NP];
    logic [NP-1:0] hold_m, force_stall, in_pkt, no_rdy_m, exp_rdy;
    bit          rdy_chk;
    int unsigned stall_pct, ready_pct, cen_pct;
    int          ready_mode, ready_idx;
    logic [3:0]  rpat = 4'b1001;
    int          model_last;
    bit          timing_chk, have_prev, frz;
    int          prev_cyc;
    logic        prev_last;
    logic [39:0] snap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_tb();
        for (int i = 0; i < NP; i++) begin
            src_q[i].delete();
            pend_q[i].delete();
            acc_cnt[i] = 0;
        end
        exp_q.delete();
        in_pkt = '0; hold_m = '0; force_stall = '0; no_rdy_m = '0; exp_rdy = '0;
        rdy_chk = 0; model_last = NP - 1; frz = 0; have_prev = 0;
    endtask

    task automatic push_beat(input int p, input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
        beat_t b;
        b.data = d; b.strb = s; b.last = l; b.id = '0;
        pend_q[p].push_back(b);
    endtask

    // Round-robin at packet granularity over every port that still has a packet queued.
    task automatic predict();
        int   p;
        bit   found;
        int   c;
        beat_t b;
        while (1) begin
            found = 0; p = 0;
            for (int k = 1; k <= NP; k++) begin
                c = (model_last + k) % NP;
                if (!found && pend_q[c].size() > 0) begin p = c; found = 1; end
            end
            if (!found) break;
            model_last = p;
            do begin
                b = pend_q[p].pop_front();
                b.id = IW'(p);
                src_q[p].push_back(b);
                exp_q.push_back(b);
            end while (!b.last);
        end
    endtask

    task automatic drive_inputs();
        logic stall;
        cen = (cen_pct >= 100) ? 1'b1 : ($urandom_range(99) < cen_pct);
        case (ready_mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = ($urandom_range(99) < ready_pct);
            default: begin dout_ready = rpat[2'(ready_idx % 4)]; ready_idx++; end
        endcase
        for (int i = 0; i < NP; i++) begin
            stall = force_stall[i] | (in_pkt[i] & ($urandom_range(99) < stall_pct));
            if (src_q[i].size() > 0 && !hold_m[i] && !stall) begin
                din[i*DW +: DW]      = src_q[i][0].data;
                din_strb[i*SW +: SW] = src_q[i][0].strb;
                din_last[i]          = src_q[i][0].last;
                din_valid[i]         = 1'b1;
            end else begin
                din[i*DW +: DW]      = $urandom;
                din_strb[i*SW +: SW] = SW'($urandom);
                din_last[i]          = 1'($urandom_range(1));
                din_valid[i]         = 1'b0;
            end
        end
    endtask

    task automatic score(input beat_t ob);
        beat_t e;
        chk("beat_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("dout_id", 64'(ob.id), 64'(e.id));
        chk("dout_payload", 64'({ob.data, ob.strb, ob.last}), 64'({e.data, e.strb, e.last}));
        if (timing_chk && have_prev)
            chk("beat_spacing", 64'(cyc - prev_cyc), prev_last ? 64'(2) : 64'(1));
        have_prev = 1; prev_cyc = cyc; prev_last = ob.last;
    endtask

    task automatic cycle();
        logic [NP-1:0] hs_in;
        logic          hs_out;
        beat_t         ob;
        @(negedge clk);
        drive_inputs();
        #1;
        chk("din_ready_onehot", 64'($countones(din_ready) <= 1), 64'(1));
        if (!cen) chk("din_ready_cen0", 64'(din_ready), 64'(0));
        if (no_rdy_m != '0) chk("din_ready_locked", 64'(din_ready & no_rdy_m), 64'(0));
        if (rdy_chk) chk("din_ready_grant", 64'(din_ready), 64'(exp_rdy));
        if (frz) chk("out_hold", 64'({dout, dout_strb, dout_last, dout_id, dout_valid}), 64'(snap));
        ob.data = dout; ob.strb = dout_strb; ob.last = dout_last; ob.id = dout_id;
        hs_in  = din_valid & din_ready;
        hs_out = dout_valid & dout_ready & cen;
        frz    = (dout_valid & ~dout_ready) | ~cen;
        snap   = {dout, dout_strb, dout_last, dout_id, dout_valid};
        @(posedge clk);
        cyc++;
        for (int i = 0; i < NP; i++) begin
            if (hs_in[i]) begin
                in_pkt[i] = ~src_q[i][0].last;
                acc_cnt[i]++;
                src_q[i].delete(0);
            end
        end
        if (hs_out) score(ob);
    endtask

    task automatic run_until_drained(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin cycle(); n++; end
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
        repeat (3) cycle();
    endtask

    initial begin
        int n;
        rstn = 1'b0; cen = 1'b1; dout_ready = 1'b1;
        din = '0; din_strb = '0; din_last = '0; din_valid = '1;
        stall_pct = 0; ready_pct = 100; cen_pct = 100; ready_mode = 0; ready_idx = 0;
        timing_chk = 0;
        clear_tb();

        // Reset state with every port requesting.
        #12;
        chk("rst_outputs", 64'({dout, dout_strb, dout_last, dout_id, dout_valid}), 64'(0));
        chk("rst_din_ready", 64'(din_ready), 64'(0));
        @(negedge clk); rstn = 1'b1;

        // Asynchronous reset in the middle of traffic.
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < 4; b++) push_beat(p, DW'(p * 256 + b), 4'hF, b == 3);
        predict();
        repeat (6) cycle();
        @(negedge clk); #2; rstn = 1'b0; #1;
        chk("midrst_outputs", 64'({dout, dout_strb, dout_last, dout_id, dout_valid}), 64'(0));
        chk("midrst_din_ready", 64'(din_ready), 64'(0));
        clear_tb();
        cycle();
        @(negedge clk); rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle(); #1;
            chk("idle_valid", 64'(dout_valid), 64'(0));
        end

        // Round-robin order with 2-beat packets, one bubble between packets.
        timing_chk = 1; have_prev = 0;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++)
                for (int b = 0; b < 2; b++) push_beat(p, DW'(p * 256 + b), 4'hF, b == 1);
        predict();
        run_until_drained("rr", 200);

        // Packet lock: port 0 raises valid while port 2's packet is open.
        have_prev = 0;
        for (int b = 0; b < 5; b++) push_beat(2, DW'(32'h200 + b), 4'hF, b == 4);
        predict();
        for (int b = 0; b < 3; b++) push_beat(0, DW'(32'h0A0 + b), 4'hF, b == 2);
        hold_m[0] = 1'b1;
        predict();
        acc_cnt[2] = 0; n = 0;
        while (acc_cnt[2] < 1 && n < 50) begin cycle(); n++; end
        chk("lock_first_beat", 64'(acc_cnt[2]), 64'(1));
        hold_m[0] = 1'b0; no_rdy_m = 4'b0001; n = 0;
        while (acc_cnt[2] < 5 && n < 50) begin cycle(); n++; end
        chk("lock_all_beats", 64'(acc_cnt[2]), 64'(5));
        no_rdy_m = '0;
        run_until_drained("lock", 100);

        // Backpressure on a 4-beat packet with mixed strobes.
        timing_chk = 0; ready_mode = 2; ready_idx = 0;
        push_beat(3, 32'h3000_0000, 4'hF, 1'b0);
        push_beat(3, 32'h3000_0001, 4'hF, 1'b0);
        push_beat(3, 32'h3000_0002, 4'h3, 1'b0);
        push_beat(3, 32'h3000_0003, 4'h1, 1'b1);
        predict();
        run_until_drained("bp", 100);
        ready_mode = 0;

        // Source stall keeps the grant; cen=0 freezes everything.
        for (int b = 0; b < 6; b++) push_beat(1, DW'(32'h1100 + b), 4'hF, b == 5);
        predict();
        acc_cnt[1] = 0; n = 0;
        while (acc_cnt[1] < 2 && n < 50) begin cycle(); n++; end
        force_stall[1] = 1'b1; rdy_chk = 1; exp_rdy = 4'b0010;
        repeat (3) cycle();
        force_stall[1] = 1'b0; rdy_chk = 0; n = 0;
        while (acc_cnt[1] < 4 && n < 50) begin cycle(); n++; end
        chk("stall_resume", 64'(acc_cnt[1]), 64'(4));
        cen_pct = 0;
        repeat (4) cycle();
        cen_pct = 100;
        run_until_drained("stall", 100);

        // Lone requester: single-beat packets re-granted every other cycle.
        timing_chk = 1; have_prev = 0;
        for (int k = 0; k < 3; k++) push_beat(1, DW'(32'h5100 + k), 4'hF, 1'b1);
        predict();
        run_until_drained("lone", 50);

        // Randomized traffic, backpressure, cen and mid-packet source stalls.
        timing_chk = 0; ready_mode = 1; ready_pct = 70; cen_pct = 90; stall_pct = 20;
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < NP; p++) begin
                int npk;
                int len;
                npk = int'($urandom_range(1, 4));
                for (int k = 0; k < npk; k++) begin
                    len = int'($urandom_range(1, 6));
                    for (int b = 0; b < len; b++)
                        push_beat(p, $urandom, SW'($urandom_range(1, 15)), b == len - 1);
                end
            end
            predict();
            run_until_drained("rand", 5000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
